pixel_readout_controller: RTL

PIXEL_READOUT_CONTROLLER -- requirements
Module: pixel_readout_controller

---
 rtl/pixel_readout_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_readout_controller.sv
// pixel_readout_controller
// Reads a frame out of a pixel array one row at a time: selects a row, captures
// its codes into a row register, then streams the row as P-pixel beats over a
// valid/ready handshake. All outputs come straight from flops.
// Optional feature: define PIXEL_READOUT_TESTPATTERN_EN to add a TEST_MODE input
// that replaces every pixel with its linear index (row*WIDTH+i) for the frame.
module pixel_readout_controller #(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 10
) (
  input  logic                                        SYSTEM_CLK,
  input  logic                                        SYSTEM_RESET,
  input  logic                                        START,
  input  logic                                        ABORT,
`ifdef PIXEL_READOUT_TESTPATTERN_EN
  input  logic                                        TEST_MODE,
`endif
  output logic [HEIGHT-1:0]                           ROW_SELECT,
  input  logic [WIDTH*BIT_DEPTH-1:0]                  ROW_DATA,
  output logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] OUT_DATA,
  output logic                                        OUT_VALID,
  input  logic                                        OUT_READY,
  output logic                                        OUT_FIRST,
  output logic                                        OUT_LAST,
  output logic                                        BUSY,
  output logic                                        DONE
);

  localparam int P         = OUTPUT_BUS_PIXEL_WIDTH;
  localparam int BEATS     = WIDTH / P;
  localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BITS = P * BIT_DEPTH;
  localparam int ROW_BITS  = WIDTH * BIT_DEPTH;

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // A row must split into a whole number of beats.
  generate
    if (WIDTH % P != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SHIFT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ROW_BITS-1:0]   row_reg_q, row_reg_d;
  logic [ROW_BITS-1:0]   capture_data;

  logic [HEIGHT-1:0]     row_select_q, row_select_d;
  logic [BEAT_BITS-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_first_q, out_first_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef PIXEL_READOUT_TESTPATTERN_EN
  logic                  test_q, test_d;
  logic [ROW_BITS-1:0]   pattern_data;

  // Test pattern for the row being selected: each slot carries its linear index.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pattern
    assign pattern_data[gi*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'(32'(row_q) * WIDTH + gi);
  end

  assign capture_data = test_q ? pattern_data : ROW_DATA;
`else
  assign capture_data = ROW_DATA;
`endif

  // Next-state logic: ABORT beats a transfer, and in IDLE it also beats START.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    beat_d    = beat_q;
    row_reg_d = row_reg_q;
    done_d    = 1'b0;
`ifdef PIXEL_READOUT_TESTPATTERN_EN
    test_d    = test_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          state_d = ST_SELECT;
          row_d   = '0;
          beat_d  = '0;
`ifdef PIXEL_READOUT_TESTPATTERN_EN
          test_d  = TEST_MODE;
`endif
        end
      end
      ST_SELECT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          row_d   = '0;
          beat_d  = '0;
        end else begin
          row_reg_d = capture_data;
          beat_d    = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          row_d   = '0;
          beat_d  = '0;
        end else if (OUT_READY) begin
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + BEAT_W'(1);
          end else if (row_q != LAST_ROW) begin
            row_d   = row_q + ROW_W'(1);
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
            row_d   = '0;
            beat_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so they can be registered.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    out_valid_d  = (state_d == ST_SHIFT);
    row_select_d = busy_d ? (HEIGHT'(1) << row_d) : '0;
    out_data_d   = out_valid_d ? row_reg_d[32'(beat_d) * BEAT_BITS +: BEAT_BITS] : '0;
    out_first_d  = out_valid_d && (row_d == '0) && (beat_d == '0);
    out_last_d   = out_valid_d && (row_d == LAST_ROW) && (beat_d == LAST_BEAT);
  end

  // All state and output registers; reset wins over every other input.
  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RESET) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      beat_q       <= '0;
      row_reg_q    <= '0;
      row_select_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PIXEL_READOUT_TESTPATTERN_EN
      test_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      beat_q       <= beat_d;
      row_reg_q    <= row_reg_d;
      row_select_q <= row_select_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef PIXEL_READOUT_TESTPATTERN_EN
      test_q       <= test_d;
`endif
    end
  end

  assign ROW_SELECT = row_select_q;
  assign OUT_DATA   = out_data_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_FIRST  = out_first_q;
  assign OUT_LAST   = out_last_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule
